// File: rtl/divider_pkg.sv
// divider_pkg: shared definitions for the constant-time restoring divider.
//   state_e   - FSM state encoding (IDLE/RUN/DONE, 2 bits)
//   cnt_width - width of the step counter for a given operand width
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/divider_step.sv
// divider_step: one combinational restoring-division step.
//   r_i  [WIDTH-1:0]  partial remainder
//   q_i  [WIDTH-1:0]  dividend/quotient shift register
//   d_i  [WIDTH-1:0]  divisor
//   r_o  [WIDTH-1:0]  next partial remainder
//   q_o  [WIDTH-1:0]  next shift register (quotient bit shifted in at LSB)
// Shift and trial subtraction are always computed; the result is a mux,
// so the step takes the same path regardless of operand values.
module divider_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] s;
  logic [WIDTH:0] t;

  always_comb begin
    s = {r_i, q_i[WIDTH-1]};
    t = s - {1'b0, d_i};
    // t[WIDTH] set means the trial subtraction borrowed: restore.
    // The kept value always fits in WIDTH bits: a restored remainder is
    // below D, and with D=0 the remainder only ever holds the dividend's
    // leading bits, so the (WIDTH+1)-bit working value's MSB stays zero.
    if (t[WIDTH]) begin
      r_o = s[WIDTH-1:0];
      q_o = {q_i[WIDTH-2:0], 1'b0};
    end else begin
      r_o = t[WIDTH-1:0];
      q_o = {q_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/divider_constant_time.sv
// divider_constant_time: sequential restoring divider with latency fixed
// at WIDTH cycles from the accepting edge to productDone, for all operands
// including divide-by-zero (quotient = all ones, remainder = dividend).
//   clk, rst     clock, asynchronous active-high reset
//   start        request, sampled only in IDLE
//   dividend     numerator, captured on the accepting edge
//   divisor      denominator, captured on the accepting edge
//   quotient     registered result, held until next completion/reset
//   remainder    registered result, held until next completion/reset
//   productDone  one-cycle completion pulse (state DONE)
//   busy         high whenever not IDLE
//   divByZero    registered flag, captured divisor was zero
module divider_constant_time
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             productDone,
  output logic             busy,
  output logic             divByZero
);

  localparam int unsigned     CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic [WIDTH-1:0] r_q,     r_d;
  logic [WIDTH-1:0] dv_q,    dv_d;
  logic [WIDTH-1:0] quot_q,  quot_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic             dbz_q,   dbz_d;

  logic [WIDTH-1:0] step_r;
  logic [WIDTH-1:0] step_q;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (dv_q),
    .r_o (step_r),
    .q_o (step_q)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dv_q    <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dv_q    <= dv_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    cnt_d  = cnt_q;
    q_d    = q_q;
    r_d    = r_q;
    dv_d   = dv_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          q_d   = dividend;
          r_d   = '0;
          dv_d  = divisor;
          cnt_d = '0;
          dbz_d = (divisor == '0);
        end
      end
      RUN: begin
        q_d   = step_q;
        r_d   = step_r;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          quot_d = step_q;
          rem_d  = step_r;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy        = (state_q != IDLE);
    productDone = (state_q == DONE);
    quotient    = quot_q;
    remainder   = rem_q;
    divByZero   = dbz_q;
  end

endmodule

// File: tb/tb_divider_constant_time.sv
module tb_divider_constant_time;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dvd_a, dvs_a, dvd_b, dvs_b;
  logic [W-1:0] quo_a, rem_a, quo_b, rem_b;
  logic         done_a, busy_a, dbz_a, done_b, busy_b, dbz_b;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  divider_constant_time #(.WIDTH(W)) u_a (
    .clk(clk), .rst(rst), .start(start),
    .dividend(dvd_a), .divisor(dvs_a),
    .quotient(quo_a), .remainder(rem_a),
    .productDone(done_a), .busy(busy_a), .divByZero(dbz_a)
  );

  divider_constant_time #(.WIDTH(W)) u_b (
    .clk(clk), .rst(rst), .start(start),
    .dividend(dvd_b), .divisor(dvs_b),
    .quotient(quo_b), .remainder(rem_b),
    .productDone(done_b), .busy(busy_b), .divByZero(dbz_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer division, divide-by-zero gives all ones / dividend.
  function automatic int unsigned ref_quo(input int unsigned a, input int unsigned b);
    return (b == 0) ? (2**W - 1) : (a / b);
  endfunction

  function automatic int unsigned ref_rem(input int unsigned a, input int unsigned b);
    return (b == 0) ? a : (a % b);
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_quo_a"},  32'(quo_a),  0);
    check({tag, "_rem_a"},  32'(rem_a),  0);
    check({tag, "_done_a"}, 32'(done_a), 0);
    check({tag, "_busy_a"}, 32'(busy_a), 0);
    check({tag, "_dbz_a"},  32'(dbz_a),  0);
    check({tag, "_quo_b"},  32'(quo_b),  0);
    check({tag, "_busy_b"}, 32'(busy_b), 0);
  endtask

  // One operation on both instances with a common start pulse.
  task automatic run_pair(input int unsigned a, input int unsigned b,
                          input int unsigned c, input int unsigned d);
    int lat;
    @(negedge clk);
    dvd_a = W'(a); dvs_a = W'(b);
    dvd_b = W'(c); dvs_b = W'(d);
    start = 1'b1;
    @(posedge clk);                      // E0
    #1;
    start = 1'b0;
    dvd_a = W'($urandom); dvs_a = W'($urandom);
    dvd_b = W'($urandom); dvs_b = W'($urandom);
    check("busy_after_e0", 32'(busy_a), 1);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (done_a || done_b) begin
        lat = i;
        break;
      end
    end
    check("latency", 32'(lat), W);
    check("done_a", 32'(done_a), 1);
    check("done_b", 32'(done_b), 1);
    check("quo_a", 32'(quo_a), ref_quo(a, b));
    check("rem_a", 32'(rem_a), ref_rem(a, b));
    check("dbz_a", 32'(dbz_a), (b == 0) ? 1 : 0);
    check("quo_b", 32'(quo_b), ref_quo(c, d));
    check("rem_b", 32'(rem_b), ref_rem(c, d));
    check("dbz_b", 32'(dbz_b), (d == 0) ? 1 : 0);
    @(posedge clk);                      // E_WIDTH+1
    #1;
    check("done_fall", 32'(done_a), 0);
    check("busy_fall_a", 32'(busy_a), 0);
    check("busy_fall_b", 32'(busy_b), 0);
    check("hold_quo_a", 32'(quo_a), ref_quo(a, b));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dvd_a = '0; dvs_a = '0; dvd_b = '0; dvs_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed cases; all share the same latency
    run_pair(13, 4, $urandom_range(15), $urandom_range(15));
    run_pair(15, 1, $urandom_range(15), $urandom_range(15));
    run_pair(0, 15, $urandom_range(15), $urandom_range(15));
    run_pair(7, 0, $urandom_range(15), $urandom_range(15));

    // start held high: an accept every W+2 cycles, start ignored while busy
    @(negedge clk);
    dvd_a = 4'd9; dvs_a = 4'd2; dvd_b = 4'd9; dvs_b = 4'd2;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("b2b_done", 32'(done_a), ((i % (W + 2)) == W) ? 1 : 0);
      if (done_a) begin
        check("b2b_quo", 32'(quo_a), 4);
        check("b2b_rem", 32'(rem_a), 1);
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (W + 3) @(posedge clk);

    // Reset two cycles into RUN
    @(negedge clk);
    dvd_a = 4'd13; dvs_a = 4'd4; dvd_b = 4'd11; dvs_b = 4'd3;
    start = 1'b1;
    @(posedge clk);                      // E0
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_idle_zero("midrun_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("no_done_after_rst", 32'(done_a | done_b), 0);
    end
    run_pair(10, 3, $urandom_range(15), $urandom_range(15));

    // Exhaustive operands on A, random operands on B, common start
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_pair(a, b, $urandom_range(15), $urandom_range(15));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
